shift_arbiter: RTL and testbench
================================

Name: shift_arbiter

Overview:
Shares the single combinational 32-bit left barrel shifter between two requesters: port 0 is the EX-stage ALU, and port 1 is the multi-cycle mul/div sequencer. The block arbitrates round-robin with a valid/ready handshake. It configures the shifter operands so that logical-right and arithmetic-right shifts reuse the left-only datapath (bit reversal plus sign fill). Each result is held in a single output register until the consumer accepts it.

Parameters:
W, 32, datapath width; only 32 is supported.
SHW, 5, shift-amount width, equal to log2(W).

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
req0_valid  in  1  requester 0 has a shift request.
req0_ready  out  1  requester 0 request accepted this cycle.
req0_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 pass-through.
req0_data  in  32  operand to shift.
req0_amt  in  5  shift amount.
req1_valid, req1_ready, req1_op, req1_data, req1_amt  same widths and meaning as the requester 0 signals, for requester 1.
rsp_valid  out  1  result register holds a valid result.
rsp_ready  in  1  consumer accepts the result this cycle.
rsp_id  out  1  requester that owns the result.
rsp_data  out  32  shifted result.
sh_a  out  32  data operand driven to the shared shifter.
sh_b  out  32  shift amount driven to the shared shifter, as {27'b0, amt}.
sh_out  in  32  shifter result, combinational from sh_a and sh_b: sh_a << sh_b[4:0].

Behaviour:
- Reset value of every output:
  - rsp_valid = 0, rsp_id = 0, rsp_data = 0.
  - Round-robin pointer selects requester 0 first.
  - While reset is high, req0_ready = req1_ready = 0 and sh_a = sh_b = 0.
- FSM has two states:
  - EMPTY: rsp_valid = 0.
  - FULL: rsp_valid = 1.
- Slot free: slot_free = EMPTY | (FULL & rsp_ready).
- Grant (combinational):
  - Only one requester valid: that requester is granted.
  - Both valid: the requester the pointer favours is granted.
  - reqN_ready = slot_free & grant == N & !reset.
- Transfer occurs when reqN_valid & reqN_ready.
- On a transfer:
  - Pointer moves to favour the other requester.
  - rsp_data, rsp_id and rsp_valid = 1 load at the clock edge.
  - The pointer does not move in any cycle without a transfer.
- Latency: the result is visible exactly 1 cycle after the accept cycle.
- With rsp_ready held high, throughput is 1 result per cycle.
- FSM transitions:
  - EMPTY -> FULL on a transfer.
  - FULL -> EMPTY when rsp_ready is high and there is no transfer.
  - FULL -> FULL on rsp_ready plus a same-cycle transfer (back-to-back).
  - FULL -> FULL, holding, when rsp_ready is low; rsp_id and rsp_data stay stable.
- Operand configuration in the accept cycle (d = granted data, n = granted amt):
  - SLL: sh_a = d, sh_b = n, result = sh_out.
  - SRL: sh_a = bitrev(d), sh_b = n, result = bitrev(sh_out).
  - SRA: as SRL, then OR in the sign fill. If d[31] = 1, result |= ~(32'hFFFFFFFF >> n); otherwise no fill.
  - Pass-through (op 11): sh_a = d, sh_b = 0, result = d.
  - When nothing is granted, sh_a = 0 and sh_b = 0.
- Boundary conditions:
  - n = 0 returns d unchanged for every op.
  - n = 31 is legal: SLL keeps d[0] at bit 31; SRL keeps d[31] at bit 0; SRA gives all-sign bits.
  - A requester may drop valid without being granted; no state changes.
  - Request signals need not be held once accepted.
  - Reset mid-operation discards any pending result: rsp_valid = 0 on the next cycle, regardless of rsp_ready.
- No combinational path from rsp_ready to rsp_data.

Test Plan:
- Reset, then req0 SLL d=0x00000001 n=4, rsp_ready=1 -> req0_ready=1 in that cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=0x00000010, sh_a=0x00000001 during accept.
- req1 SRL d=0x80000000 n=31 -> rsp_data=0x00000001. req1 SRA d=0x80000000 n=4 -> rsp_data=0xF8000000. SRA d=0x7FFFFFFF n=4 -> 0x07FFFFFF.
- Both valid every cycle, rsp_ready=1, starting right after reset -> grant order 0,1,0,1; rsp_id alternates 0,1,0,1, with one result per cycle.
- rsp_ready=0 while FULL -> both readies 0; rsp_data and rsp_id stable for 5 cycles. Raise rsp_ready -> a new request is accepted that cycle, and the new rsp_data appears next cycle with rsp_valid continuous.
- Reset high for one cycle while FULL with rsp_ready=0 -> next cycle rsp_valid=0, rsp_data=0; first grant after reset goes to req0 with both valid.
- op=11 d=0x12345678 n=7 -> rsp_data=0x12345678 and sh_b=0 in the accept cycle. Any op with n=0 and d=0xDEADBEEF -> 0xDEADBEEF.

Source files
------------

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - round-robin arbiter sharing one left barrel shifter between two requesters
module shift_arbiter #(
    parameter int W   = 32,
    parameter int SHW = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [1:0]     req0_op,
    input  logic [W-1:0]   req0_data,
    input  logic [SHW-1:0] req0_amt,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [1:0]     req1_op,
    input  logic [W-1:0]   req1_data,
    input  logic [SHW-1:0] req1_amt,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [W-1:0]   rsp_data,
    output logic [W-1:0]   sh_a,
    output logic [W-1:0]   sh_b,
    input  logic [W-1:0]   sh_out
);

    typedef enum logic {EMPTY, FULL} state_t;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;

    state_t         state, state_nxt;
    logic           ptr;
    logic           slot_free, gnt0, gnt1, xfer0, xfer1, xfer;
    logic [1:0]     sel_op;
    logic [W-1:0]   sel_d;
    logic [SHW-1:0] sel_n;
    logic [W-1:0]   result;

    function automatic logic [W-1:0] bitrev(input logic [W-1:0] x);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = x[W-1-i];
        return r;
    endfunction

    always_comb begin
        slot_free  = (state == EMPTY) | rsp_ready;
        // ptr = 0 favours requester 0 when both are valid
        gnt0       = req0_valid & (~req1_valid | ~ptr);
        gnt1       = req1_valid & (~req0_valid | ptr);
        req0_ready = slot_free & gnt0 & ~reset;
        req1_ready = slot_free & gnt1 & ~reset;
        xfer0      = req0_valid & req0_ready;
        xfer1      = req1_valid & req1_ready;
        xfer       = xfer0 | xfer1;

        sel_op = xfer1 ? req1_op   : req0_op;
        sel_d  = xfer1 ? req1_data : req0_data;
        sel_n  = xfer1 ? req1_amt  : req0_amt;

        sh_a   = '0;
        sh_b   = '0;
        result = sel_d;
        if (xfer) begin
            // right shifts run through the left-only shifter by mirroring in and out
            case (sel_op)
                OP_SLL: begin
                    sh_a   = sel_d;
                    sh_b   = {{(W-SHW){1'b0}}, sel_n};
                    result = sh_out;
                end
                OP_SRL: begin
                    sh_a   = bitrev(sel_d);
                    sh_b   = {{(W-SHW){1'b0}}, sel_n};
                    result = bitrev(sh_out);
                end
                OP_SRA: begin
                    sh_a   = bitrev(sel_d);
                    sh_b   = {{(W-SHW){1'b0}}, sel_n};
                    result = bitrev(sh_out) |
                             (sel_d[W-1] ? ~({W{1'b1}} >> sel_n) : {W{1'b0}});
                end
                default: begin
                    sh_a   = sel_d;
                    sh_b   = '0;
                    result = sel_d;
                end
            endcase
        end

        state_nxt = state;
        case (state)
            EMPTY:   if (xfer) state_nxt = FULL;
            FULL:    if (rsp_ready && !xfer) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    assign rsp_valid = (state == FULL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= EMPTY;
            ptr      <= 1'b0;
            rsp_id   <= 1'b0;
            rsp_data <= '0;
        end else begin
            state <= state_nxt;
            if (xfer) begin
                ptr      <= xfer0;
                rsp_id   <= xfer1;
                rsp_data <= result;
            end
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - scoreboard bench for shift_arbiter with a behavioural shifter
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0]  req0_op, req1_op;
    logic [31:0] req0_data, req1_data;
    logic [4:0]  req0_amt, req1_amt;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_data, sh_a, sh_b, sh_out;

    int n_cmp = 0;
    int n_err = 0;
    logic [32:0] exp_q[$];
    logic        exp_gnt;

    always #5 clk = ~clk;

    assign sh_out = sh_a << sh_b[4:0];

    shift_arbiter #(.W(32), .SHW(5)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_data(req0_data), .req0_amt(req0_amt),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_data(req1_data), .req1_amt(req1_amt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .sh_a(sh_a), .sh_b(sh_b), .sh_out(sh_out)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] d,
                                          input logic [4:0] n);
        case (op)
            2'b00:   return d << n;
            2'b01:   return d >> n;
            2'b10:   return $unsigned($signed(d) >>> n);
            default: return d;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic [1:0] op, input logic [31:0] d, input logic [4:0] n);
        req0_valid = v; req0_op = op; req0_data = d; req0_amt = n;
    endtask

    task automatic set1(input logic v, input logic [1:0] op, input logic [31:0] d, input logic [4:0] n);
        req1_valid = v; req1_op = op; req1_data = d; req1_amt = n;
    endtask

    // Scoreboard: retire on the consumer handshake first, then record the newly accepted request
    always @(negedge clk) begin
        if (!reset) begin
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    chk("rsp_id", {31'd0, rsp_id}, {31'd0, e[32]});
                    chk("rsp_data", rsp_data, e[31:0]);
                end
            end
            if (req0_valid && req0_ready) exp_q.push_back({1'b0, model(req0_op, req0_data, req0_amt)});
            if (req1_valid && req1_ready) exp_q.push_back({1'b1, model(req1_op, req1_data, req1_amt)});
        end
    end

    initial begin
        reset = 1'b1; rsp_ready = 1'b0;
        set0(0, 0, 0, 0); set1(0, 0, 0, 0);

        // reset: no grants and idle shifter operands even with requests pending
        tick();
        set0(1, 2'b00, 32'h1, 5'd3); set1(1, 2'b01, 32'h2, 5'd3);
        @(negedge clk);
        chk("reset_req0_ready", {31'd0, req0_ready}, 32'd0);
        chk("reset_req1_ready", {31'd0, req1_ready}, 32'd0);
        chk("reset_sh_a", sh_a, 32'd0);
        chk("reset_sh_b", sh_b, 32'd0);
        tick();
        reset = 1'b0; set0(0, 0, 0, 0); set1(0, 0, 0, 0);
        @(negedge clk);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_id", {31'd0, rsp_id}, 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);

        // first SLL and its one-cycle latency
        tick();
        rsp_ready = 1'b1; set0(1, 2'b00, 32'h1, 5'd4);
        @(negedge clk);
        chk("sll_req0_ready", {31'd0, req0_ready}, 32'd1);
        chk("sll_sh_a", sh_a, 32'h1);
        chk("sll_sh_b", sh_b, 32'd4);
        tick();
        set0(0, 0, 0, 0);
        @(negedge clk);
        chk("sll_rsp_valid", {31'd0, rsp_valid}, 32'd1);

        // right shifts from requester 1, back to back
        tick(); set1(1, 2'b01, 32'h8000_0000, 5'd31);
        @(negedge clk); chk("srl_req1_ready", {31'd0, req1_ready}, 32'd1);
        tick(); set1(1, 2'b10, 32'h8000_0000, 5'd4);
        @(negedge clk); chk("sra_neg_ready", {31'd0, req1_ready}, 32'd1);
        tick(); set1(1, 2'b10, 32'h7FFF_FFFF, 5'd4);
        @(negedge clk); chk("sra_pos_ready", {31'd0, req1_ready}, 32'd1);
        tick(); set1(1, 2'b10, 32'hF000_0001, 5'd31);
        @(negedge clk); chk("sra_n31_ready", {31'd0, req1_ready}, 32'd1);
        tick(); set0(1, 2'b00, 32'h0000_0003, 5'd31); set1(0, 0, 0, 0);
        @(negedge clk); chk("sll_n31_ready", {31'd0, req0_ready}, 32'd1);
        tick(); set0(0, 0, 0, 0);
        @(negedge clk);

        // fresh reset, then both requesters valid every cycle: strict alternation
        tick(); reset = 1'b1;
        tick(); reset = 1'b0;
        exp_gnt = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            set0(1, 2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)));
            set1(1, 2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)));
            @(negedge clk);
            chk("rr_req0_ready", {31'd0, req0_ready}, {31'd0, ~exp_gnt});
            chk("rr_req1_ready", {31'd0, req1_ready}, {31'd0, exp_gnt});
            if (i > 0) chk("rr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            exp_gnt = ~exp_gnt;
        end

        // consumer stalls: result held, nothing accepted
        tick(); rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            @(negedge clk);
            chk("hold_req0_ready", {31'd0, req0_ready}, 32'd0);
            chk("hold_req1_ready", {31'd0, req1_ready}, 32'd0);
            chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_rsp_data", rsp_data, exp_q[0][31:0]);
            chk("hold_rsp_id", {31'd0, rsp_id}, {31'd0, exp_q[0][32]});
        end
        tick(); rsp_ready = 1'b1;
        @(negedge clk);
        chk("release_ready", {31'd0, (exp_gnt ? req1_ready : req0_ready)}, 32'd1);
        tick(); set0(0, 0, 0, 0); set1(0, 0, 0, 0);
        @(negedge clk);
        chk("release_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        tick();
        @(negedge clk);
        chk("drain_rsp_valid", {31'd0, rsp_valid}, 32'd0);

        // reset while FULL and stalled discards the pending result
        tick(); rsp_ready = 1'b0; set1(1, 2'b00, 32'hABCD_0000, 5'd1);
        tick(); set1(0, 0, 0, 0); reset = 1'b1;
        tick(); reset = 1'b0; exp_q.delete();
        @(negedge clk);
        chk("rst_full_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_full_rsp_data", rsp_data, 32'd0);
        tick(); rsp_ready = 1'b1;
        set0(1, 2'b01, 32'h0000_F000, 5'd8); set1(1, 2'b00, 32'h1, 5'd1);
        @(negedge clk);
        chk("rst_first_req0", {31'd0, req0_ready}, 32'd1);
        chk("rst_first_req1", {31'd0, req1_ready}, 32'd0);

        // pass-through ignores the amount
        tick(); set0(0, 0, 0, 0); set1(1, 2'b11, 32'h1234_5678, 5'd7);
        @(negedge clk);
        chk("pass_ready", {31'd0, req1_ready}, 32'd1);
        chk("pass_sh_b", sh_b, 32'd0);
        chk("pass_sh_a", sh_a, 32'h1234_5678);

        // zero shift returns the operand for every op
        set1(0, 0, 0, 0);
        for (int op = 0; op < 4; op++) begin
            tick(); set0(1, 2'(op), 32'hDEAD_BEEF, 5'd0);
            @(negedge clk);
            chk("n0_ready", {31'd0, req0_ready}, 32'd1);
        end
        tick(); set0(0, 0, 0, 0);
        tick(); tick();
        @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
